// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready bitwise-op pipeline with a wrapping delivered-result counter.
// Optional registered zero flag on the result when LOGIC_OP_ZERO_FLAG_EN is defined.
module logic_op_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] result_count
`ifdef LOGIC_OP_ZERO_FLAG_EN
  ,
  output logic                 out_zero
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } s1_req_t;

  s1_req_t          s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [WIDTH-1:0] op_res;
  logic             s1_adv;
  logic             s2_adv;

  // Stage 2 drains when empty or consumed; stage 1 only moves if stage 2 does.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    op_res = '0;
    case (s1_q.op)
      3'b000:  op_res = s1_q.a & s1_q.b;
      3'b001:  op_res = s1_q.a | s1_q.b;
      3'b010:  op_res = s1_q.a ^ s1_q.b;
      3'b011:  op_res = ~(s1_q.a & s1_q.b);
      3'b100:  op_res = ~(s1_q.a | s1_q.b);
      3'b101:  op_res = ~(s1_q.a ^ s1_q.b);
      3'b110:  op_res = s1_q.a;
      3'b111:  op_res = ~s1_q.a;
      default: op_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= '{a: in_a, b: in_b, op: in_op};
    end
  end

  // Data only loads with a real beat so out_data stays put across bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= op_res;
    end
  end

`ifdef LOGIC_OP_ZERO_FLAG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 out_zero <= 1'b1;
    else if (s2_adv && s1_valid)  out_zero <= (op_res == '0);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  result_count <= '0;
    else if (s2_valid && out_ready) result_count <= result_count + CNT_WIDTH'(1);
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Randomized + directed bench for logic_op_pipe against a queue-based occupancy/age model.
module tb_logic_op_pipe;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [7:0] result_count;
`ifdef LOGIC_OP_ZERO_FLAG_EN
  logic       out_zero;
`endif

  logic_op_pipe #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .result_count(result_count)
`ifdef LOGIC_OP_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] d; int age; } ent_t;
  ent_t       q[$];
  logic [7:0] got[$];
  int         cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~a | ~b;
      3'd4: return ~a & ~b;
      3'd5: return a ^ ~b;
      3'd6: return a;
      default: return 8'hFF - a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check pre-edge outputs, advance model across posedge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic ordy, output logic acc);
    logic exp_rdy, exp_vld, dlv;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    #1;
    exp_rdy = !(q.size() == 2 && !ordy);
    exp_vld = (q.size() > 0) && (q[0].age >= 2);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("result_count", 32'(result_count), 32'(cnt % 256));
    if (exp_vld) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
`ifdef LOGIC_OP_ZERO_FLAG_EN
      chk("out_zero", 32'(out_zero), 32'(q[0].d == 8'h00));
`endif
    end
    acc = v && exp_rdy;
    dlv = exp_vld && ordy;
    @(posedge clock);
    if (dlv) begin got.push_back(q[0].d); void'(q.pop_front()); cnt++; end
    foreach (q[i]) q[i].age++;
    if (acc) q.push_back('{d: ref_op(a, b, op), age: 1});
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(result_count), 32'd0);
`ifdef LOGIC_OP_ZERO_FLAG_EN
    chk("rst_out_zero", 32'(out_zero), 32'd1);
`endif
    q.delete(); got.delete(); cnt = 0;
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int k = 0;
    while (q.size() > 0 && k < budget) begin step(1'b0, 8'h0, 8'h0, 3'd0, 1'b1, acc); k++; end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic       acc;
    logic [7:0] exp1 [8];
    logic [7:0] ra, rb;
    logic [2:0] rop;
    int         sent, cyc, acc_stall;
    cnt = 0;
    exp1 = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC5, 8'h3A};
    @(negedge clock);
    do_reset();

    // All ops, back-to-back
    for (int i = 0; i < 8; i++) step(1'b1, 8'hC5, 8'h3A, 3'(i), 1'b1, acc);
    drain(10);
    chk("t1_got_n", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_op_result", 32'(got[i]), 32'(exp1[i]));

    // Backpressure: 4 beats offered with out_ready low
    do_reset();
    sent = 0; acc_stall = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h10 + sent), 8'h0F, 3'd6, 1'b0, acc);
      if (acc) begin sent++; acc_stall++; end
    end
    chk("t2_accepts_stalled", 32'(acc_stall), 32'd2);
    cyc = 0;
    while (sent < 4 && cyc < 20) begin
      step(1'b1, 8'(8'h10 + sent), 8'h0F, 3'd6, 1'b1, acc);
      if (acc) sent++;
      cyc++;
    end
    drain(10);
    chk("t2_count", 32'(result_count), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'(8'h10 + i));

    // Streaming 300 beats, counter wraps
    do_reset();
    sent = 0; cyc = 0;
    while (sent < 300 && cyc < 400) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      step(1'b1, ra, rb, rop, 1'b1, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("t3_cycles", 32'(cyc), 32'd300);
    drain(10);
    chk("t3_count_wrap", 32'(result_count), 32'd44);

    // Random valid/ready over 1000 beats
    do_reset();
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
      step(1'($urandom), ra, rb, rop, 1'($urandom), acc);
      if (acc) sent++;
      cyc++;
    end
    drain(10);
    chk("t4_delivered", 32'(got.size()), 32'd1000);
    chk("t4_count", 32'(result_count), 32'(1000 % 256));

    // Reset with beats in flight, then one fresh beat
    step(1'b1, 8'hAA, 8'h55, 3'd2, 1'b0, acc);
    step(1'b1, 8'hAA, 8'h55, 3'd0, 1'b0, acc);
    chk("t5_inflight", 32'(q.size()), 32'd2);
    do_reset();
    step(1'b1, 8'h3C, 8'h0F, 3'd1, 1'b1, acc);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("t5_latency_valid", 32'(out_valid), 32'd1);
    chk("t5_latency_data", 32'(out_data), 32'h3F);
    drain(10);
    chk("t5_count", 32'(result_count), 32'd1);

`ifdef LOGIC_OP_ZERO_FLAG_EN
    step(1'b1, 8'h0F, 8'hF0, 3'd0, 1'b1, acc);
    step(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b1, acc);
    #1;
    chk("t6_zero_and", 32'(out_zero), 32'd1);
    @(negedge clock);
    #1;
    chk("t6_zero_or", 32'(out_zero), 32'd0);
    @(negedge clock);
    q.delete();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
